byte_calc_ctrl: RTL and testbench

Sequencing controller in front of the 8-bit byte-calculator datapath on the BASYS 3 board. It conditions the raw push-buttons: synchronise, debounce, detect the rising edge, and arbitrate simultaneous presses. On an accepted press it latches the switch operands, issues exactly one single-cycle one-hot opcode to the datapath, and waits the datapath latency. It then captures the 9-bit result and reports completion or error status to the display logic.

---
 rtl/byte_calc_pkg.sv | 48 ++++
 rtl/byte_calc_ctrl_if.sv | 39 +++
 rtl/btn_conditioner.sv | 58 +++++
 rtl/byte_calc_ctrl.sv | 166 ++++++++++++++++
 tb/tb_byte_calc_ctrl.sv | 342 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/byte_calc_pkg.sv
// Shared definitions for the byte-calculator sequencing controller.
//   state_e      : controller FSM states
//   OP_*         : one-hot datapath opcodes (bit 4 clear, 3 ADD, 2 SUB, 1 MULT, 0 DIV)
//   DIV0_RESULT  : result reported when a divide by zero is refused
//   op_grant()   : fixed-priority pick among operation requests, ADD > SUB > MULT > DIV
//   op_multi()   : more than one operation request present
package byte_calc_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StClear
  } state_e;

  localparam int unsigned OpW = 5;

  localparam logic [OpW-1:0] OP_NONE = 5'b00000;
  localparam logic [OpW-1:0] OP_CLR  = 5'b10000;
  localparam logic [OpW-1:0] OP_ADD  = 5'b01000;
  localparam logic [OpW-1:0] OP_SUB  = 5'b00100;
  localparam logic [OpW-1:0] OP_MULT = 5'b00010;
  localparam logic [OpW-1:0] OP_DIV  = 5'b00001;

  localparam logic [8:0] DIV0_RESULT = 9'h1FF;

  // req bit positions line up with the opcode bits: [3] ADD, [2] SUB, [1] MULT, [0] DIV.
  function automatic logic [OpW-1:0] op_grant(input logic [3:0] req);
    logic [OpW-1:0] grant;
    grant = OP_NONE;
    if (req[3]) begin
      grant = OP_ADD;
    end else if (req[2]) begin
      grant = OP_SUB;
    end else if (req[1]) begin
      grant = OP_MULT;
    end else if (req[0]) begin
      grant = OP_DIV;
    end
    return grant;
  endfunction

  // Clearing the lowest set bit leaves something only if two or more bits were set.
  function automatic logic op_multi(input logic [3:0] req);
    return (req & (req - 4'd1)) != 4'd0;
  endfunction

endpackage

// File: rtl/byte_calc_ctrl_if.sv
// Board-side bundle of the byte-calculator controller.
//   Buttons (raw, active-high): btn_clr, btn_add, btn_sub, btn_mult, btn_div
//   Operand switches          : sw_a, sw_b
//   Datapath                  : alu_result in; alu_a, alu_b, alu_op out
//   Status to display logic   : result_q, busy, done, err_div0, err_multi
// slave is the controller's view; master is the board / datapath / display view.
interface byte_calc_ctrl_if;

  logic       btn_clr;
  logic       btn_add;
  logic       btn_sub;
  logic       btn_mult;
  logic       btn_div;
  logic [7:0] sw_a;
  logic [7:0] sw_b;
  logic [8:0] alu_result;

  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [4:0] alu_op;
  logic [8:0] result_q;
  logic       busy;
  logic       done;
  logic       err_div0;
  logic       err_multi;

  modport slave (
    input  btn_clr, btn_add, btn_sub, btn_mult, btn_div,
    input  sw_a, sw_b, alu_result,
    output alu_a, alu_b, alu_op, result_q, busy, done, err_div0, err_multi
  );

  modport master (
    output btn_clr, btn_add, btn_sub, btn_mult, btn_div,
    output sw_a, sw_b, alu_result,
    input  alu_a, alu_b, alu_op, result_q, busy, done, err_div0, err_multi
  );

endinterface

// File: rtl/btn_conditioner.sv
// Conditions one raw push-button into a single-cycle press pulse.
//   clk       : system clock
//   reset_n   : asynchronous active-low reset
//   btn_raw   : raw asynchronous button level
//   btn_pulse : one-cycle pulse on the rising edge of the debounced level
// The accepted level only moves after DBNC_CYCLES consecutive synchronised samples that
// disagree with it; any agreeing sample restarts the count.
module btn_conditioner #(
  parameter int unsigned DBNC_CYCLES = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_raw,
  output logic btn_pulse
);

  localparam int unsigned CntW = (DBNC_CYCLES > 1) ? $clog2(DBNC_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DBNC_CYCLES - 1);

  logic            sync1_q;
  logic            sync2_q;
  logic            level_q;
  logic            level_d;
  logic            level_prev_q;
  logic [CntW-1:0] cnt_q;
  logic [CntW-1:0] cnt_d;

  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CntMax) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      sync1_q      <= btn_raw;
      sync2_q      <= sync1_q;
      level_q      <= level_d;
      level_prev_q <= level_q;
      cnt_q        <= cnt_d;
    end
  end

  assign btn_pulse = level_q & ~level_prev_q;

endmodule

// File: rtl/byte_calc_ctrl.sv
// Sequencing controller in front of the 8-bit byte-calculator datapath.
//   clk     : system clock, all state on the rising edge
//   reset_n : asynchronous active-low reset
//   bus     : board-side bundle (buttons, switches, datapath operands/opcode/result, status)
// Each button is synchronised, debounced and edge-detected. In IDLE a clear press wins;
// otherwise one operation is granted by fixed priority, operands are latched, the opcode
// is driven for one cycle, and after CALC_LAT cycles the datapath result is captured and
// done pulses. Presses outside IDLE are dropped.
module byte_calc_ctrl #(
  parameter int unsigned DBNC_CYCLES = 4,
  parameter int unsigned CALC_LAT    = 1
) (
  input logic         clk,
  input logic         reset_n,
  byte_calc_ctrl_if.slave bus
);

  import byte_calc_pkg::*;

  localparam int unsigned WaitW = (CALC_LAT > 1) ? $clog2(CALC_LAT) : 1;
  localparam logic [WaitW-1:0] WaitMax = WaitW'(CALC_LAT - 1);

  // Button conditioning; index order matches the opcode bit order.
  logic [4:0] btn_raw;
  logic [4:0] btn_pulse;

  assign btn_raw = {bus.btn_clr, bus.btn_add, bus.btn_sub, bus.btn_mult, bus.btn_div};

  for (genvar i = 0; i < 5; i++) begin : g_btn
    btn_conditioner #(
      .DBNC_CYCLES (DBNC_CYCLES)
    ) u_btn (
      .clk       (clk),
      .reset_n   (reset_n),
      .btn_raw   (btn_raw[i]),
      .btn_pulse (btn_pulse[i])
    );
  end

  logic           clr_pulse;
  logic [3:0]     op_req;
  logic [OpW-1:0] op_win;

  assign clr_pulse = btn_pulse[4];
  assign op_req    = btn_pulse[3:0];
  assign op_win    = op_grant(op_req);

  // Controller state.
  state_e          state_q, state_d;
  logic [7:0]      alu_a_q, alu_a_d;
  logic [7:0]      alu_b_q, alu_b_d;
  logic [OpW-1:0]  op_q, op_d;
  logic [8:0]      result_q, result_d;
  logic            done_q, done_d;
  logic            err_div0_q, err_div0_d;
  logic            err_multi_q, err_multi_d;
  logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;

  always_comb begin
    state_d     = state_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    op_d        = op_q;
    result_d    = result_q;
    done_d      = 1'b0;
    err_div0_d  = err_div0_q;
    err_multi_d = err_multi_q;
    wait_cnt_d  = wait_cnt_q;

    unique case (state_q)
      StIdle: begin
        if (clr_pulse) begin
          // Clear wins over any operation press in the same cycle.
          state_d     = StClear;
          result_d    = '0;
          err_div0_d  = 1'b0;
          err_multi_d = 1'b0;
        end else if (op_req != 4'd0) begin
          if (op_multi(op_req)) begin
            err_multi_d = 1'b1;
          end
          if (op_win == OP_DIV && bus.sw_b == 8'd0) begin
            // Refuse the divide: nothing reaches the datapath, report straight away.
            err_div0_d = 1'b1;
            result_d   = DIV0_RESULT;
            done_d     = 1'b1;
          end else begin
            alu_a_d = bus.sw_a;
            alu_b_d = bus.sw_b;
            op_d    = op_win;
            state_d = StIssue;
          end
        end
      end

      StIssue: begin
        state_d    = StWait;
        wait_cnt_d = '0;
      end

      StWait: begin
        if (wait_cnt_q == WaitMax) begin
          result_d = bus.alu_result;
          done_d   = 1'b1;
          state_d  = StIdle;
        end else begin
          wait_cnt_d = wait_cnt_q + WaitW'(1);
        end
      end

      StClear: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      op_q        <= OP_NONE;
      result_q    <= '0;
      done_q      <= 1'b0;
      err_div0_q  <= 1'b0;
      err_multi_q <= 1'b0;
      wait_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      op_q        <= op_d;
      result_q    <= result_d;
      done_q      <= done_d;
      err_div0_q  <= err_div0_d;
      err_multi_q <= err_multi_d;
      wait_cnt_q  <= wait_cnt_d;
    end
  end

  // Opcode and busy decode straight from the state register, so alu_op is one-hot or zero.
  logic [OpW-1:0] alu_op;

  always_comb begin
    alu_op = OP_NONE;
    unique case (state_q)
      StIssue: alu_op = op_q;
      StClear: alu_op = OP_CLR;
      default: alu_op = OP_NONE;
    endcase
  end

  assign bus.alu_a     = alu_a_q;
  assign bus.alu_b     = alu_b_q;
  assign bus.alu_op    = alu_op;
  assign bus.result_q  = result_q;
  assign bus.busy      = (state_q != StIdle);
  assign bus.done      = done_q;
  assign bus.err_div0  = err_div0_q;
  assign bus.err_multi = err_multi_q;

endmodule

// File: tb/tb_byte_calc_ctrl.sv
// Bench for byte_calc_ctrl: dut0 uses DBNC_CYCLES=4, CALC_LAT=1; dut1 uses DBNC_CYCLES=1,
// CALC_LAT=4. Each has a small behavioural datapath that computes on the opcode pulse.
module tb_byte_calc_ctrl;

  import byte_calc_pkg::*;

  localparam int unsigned Dbnc0 = 4;
  localparam int unsigned Lat0  = 1;
  localparam int unsigned Dbnc1 = 1;
  localparam int unsigned Lat1  = 4;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [4:0] op;
    logic [8:0] res;
    logic       busy;
    logic       done;
    logic       div0;
    logic       multi;
  } obs_t;

  typedef struct {
    logic [4:0] mask;
    logic [7:0] a;
    logic [7:0] b;
    logic [4:0] exp_op;
    logic [8:0] exp_res;
    logic       exp_div0;
    logic       exp_multi;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n0 = 1'b1;
  logic       rst_n1 = 1'b1;
  logic [4:0] btn0 = '0;
  logic [4:0] btn1 = '0;
  logic [7:0] swa0 = '0;
  logic [7:0] swb0 = '0;
  logic [7:0] swa1 = '0;
  logic [7:0] swb1 = '0;
  logic [8:0] dp0 = '0;
  logic [8:0] dp1 = '0;

  byte_calc_ctrl_if bus0 ();
  byte_calc_ctrl_if bus1 ();

  assign bus0.btn_clr    = btn0[4];
  assign bus0.btn_add    = btn0[3];
  assign bus0.btn_sub    = btn0[2];
  assign bus0.btn_mult   = btn0[1];
  assign bus0.btn_div    = btn0[0];
  assign bus0.sw_a       = swa0;
  assign bus0.sw_b       = swb0;
  assign bus0.alu_result = dp0;

  assign bus1.btn_clr    = btn1[4];
  assign bus1.btn_add    = btn1[3];
  assign bus1.btn_sub    = btn1[2];
  assign bus1.btn_mult   = btn1[1];
  assign bus1.btn_div    = btn1[0];
  assign bus1.sw_a       = swa1;
  assign bus1.sw_b       = swb1;
  assign bus1.alu_result = dp1;

  byte_calc_ctrl #(
    .DBNC_CYCLES (Dbnc0),
    .CALC_LAT    (Lat0)
  ) dut0 (
    .clk     (clk),
    .reset_n (rst_n0),
    .bus     (bus0)
  );

  byte_calc_ctrl #(
    .DBNC_CYCLES (Dbnc1),
    .CALC_LAT    (Lat1)
  ) dut1 (
    .clk     (clk),
    .reset_n (rst_n1),
    .bus     (bus1)
  );

  // Datapath stand-in: computes on the opcode pulse, result held until the next opcode.
  function automatic logic [8:0] dp_calc(input logic [4:0] op, input logic [7:0] a,
                                         input logic [7:0] b, input logic [8:0] prev);
    logic [15:0] p;
    p = a * b;
    case (op)
      OP_ADD:  return {1'b0, a} + {1'b0, b};
      OP_SUB:  return {1'b0, a} - {1'b0, b};
      OP_MULT: return p[8:0];
      OP_DIV:  return (b == 8'd0) ? 9'h1FF : {1'b0, a / b};
      OP_CLR:  return 9'd0;
      default: return prev;
    endcase
  endfunction

  always @(posedge clk) dp0 <= dp_calc(bus0.alu_op, bus0.alu_a, bus0.alu_b, dp0);
  always @(posedge clk) dp1 <= dp_calc(bus1.alu_op, bus1.alu_a, bus1.alu_b, dp1);

  obs_t o0, o1;
  assign o0 = {bus0.alu_a, bus0.alu_b, bus0.alu_op, bus0.result_q, bus0.busy, bus0.done,
               bus0.err_div0, bus0.err_multi};
  assign o1 = {bus1.alu_a, bus1.alu_b, bus1.alu_op, bus1.result_q, bus1.busy, bus1.done,
               bus1.err_div0, bus1.err_multi};

  function automatic obs_t get_obs(input int sel);
    return (sel == 0) ? o0 : o1;
  endfunction

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_in(input int sel, input logic [4:0] m, input logic [7:0] a,
                        input logic [7:0] b);
    if (sel == 0) begin
      btn0 = m;
      swa0 = a;
      swb0 = b;
    end else begin
      btn1 = m;
      swa1 = a;
      swb1 = b;
    end
  endtask

  task automatic set_rst(input int sel, input logic v);
    if (sel == 0) rst_n0 = v;
    else rst_n1 = v;
  endtask

  // Observations collected over one stimulus window.
  int         w_issue, w_done, w_nop, w_nmh, w_ndone, w_busy;
  logic [4:0] w_op;
  logic [7:0] w_a, w_b;
  obs_t       w_end;

  // Cycle k: sample outputs at the falling edge, then drive that cycle's inputs.
  task automatic run_window(input int sel, input logic [7:0] a, input logic [7:0] b,
                            input logic [4:0] m1, input int s1, input int e1,
                            input logic [4:0] m2, input int s2, input int e2,
                            input int rst_c, input int total);
    obs_t       o;
    logic [4:0] m;
    w_issue = -1;
    w_done  = -1;
    w_nop   = 0;
    w_nmh   = 0;
    w_ndone = 0;
    w_busy  = 0;
    w_op    = '0;
    w_a     = '0;
    w_b     = '0;
    for (int k = 0; k < total; k++) begin
      @(negedge clk);
      o = get_obs(sel);
      if (o.op != 5'd0) begin
        w_nop++;
        if (w_issue < 0) begin
          w_issue = k;
          w_op    = o.op;
          w_a     = o.a;
          w_b     = o.b;
        end
      end
      if ($countones(o.op) > 1) w_nmh++;
      if (o.done) begin
        w_ndone++;
        if (w_done < 0) w_done = k;
      end
      if (o.busy) w_busy++;
      m = 5'd0;
      if (k >= s1 && k < e1) m = m | m1;
      if (k >= s2 && k < e2) m = m | m2;
      set_in(sel, m, a, b);
      if (k == rst_c) begin
        set_rst(sel, 1'b0);
        #1;
        chk("reset_async_zero", get_obs(sel), '0);
      end
      if (rst_c >= 0 && k == rst_c + 2) set_rst(sel, 1'b1);
    end
    w_end = get_obs(sel);
  endtask

  // Press happens at window cycle 0; latency to the opcode cycle is 3 + DBNC_CYCLES samples.
  task automatic check_window(input int sel, input logic [4:0] exp_op,
                              input logic [8:0] exp_res, input logic exp_div0,
                              input logic exp_multi, input logic [7:0] a, input logic [7:0] b,
                              input string tag);
    int lat, iss;
    lat = (sel == 0) ? Lat0 : Lat1;
    iss = 3 + ((sel == 0) ? Dbnc0 : Dbnc1);
    chk({tag, "_op"}, w_op, exp_op);
    chk({tag, "_op_cycles"}, w_nop, (exp_op != 5'd0) ? 1 : 0);
    chk({tag, "_multihot"}, w_nmh, 0);
    if (exp_op != 5'd0) chk({tag, "_issue_at"}, w_issue, iss);
    if (exp_op == OP_CLR) begin
      chk({tag, "_ndone"}, w_ndone, 0);
      chk({tag, "_busy_cycles"}, w_busy, 1);
    end else if (exp_op == 5'd0) begin
      chk({tag, "_ndone"}, w_ndone, 1);
      chk({tag, "_done_at"}, w_done, iss);
      chk({tag, "_busy_cycles"}, w_busy, 0);
    end else begin
      chk({tag, "_ndone"}, w_ndone, 1);
      chk({tag, "_done_at"}, w_done, iss + 1 + lat);
      chk({tag, "_busy_cycles"}, w_busy, 1 + lat);
      chk({tag, "_alu_a"}, w_a, a);
      chk({tag, "_alu_b"}, w_b, b);
    end
    chk({tag, "_result"}, w_end.res, exp_res);
    chk({tag, "_err_div0"}, w_end.div0, exp_div0);
    chk({tag, "_err_multi"}, w_end.multi, exp_multi);
    chk({tag, "_busy_end"}, w_end.busy, 0);
  endtask

  // Reference arithmetic on plain integers, reduced to 9 bits.
  function automatic logic [8:0] ref_calc(input int which, input logic [7:0] a,
                                          input logic [7:0] b);
    int ia, ib, r;
    ia = a;
    ib = b;
    case (which)
      3:       r = (ia + ib) % 512;
      2:       r = (ia - ib + 512) % 512;
      1:       r = (ia * ib) % 512;
      default: r = ia / ib;
    endcase
    return 9'(r);
  endfunction

  vec_t       tbl [9];
  logic [8:0] m_res;
  logic       m_div0, m_multi;

  initial begin
    tbl[0] = '{OP_ADD,           8'd200, 8'd100, OP_ADD,  9'd300,  1'b0, 1'b0};
    tbl[1] = '{OP_SUB,           8'd5,   8'd10,  OP_SUB,  9'h1FB,  1'b0, 1'b0};
    tbl[2] = '{OP_MULT | OP_DIV, 8'd12,  8'd3,   OP_MULT, 9'd36,   1'b0, 1'b1};
    tbl[3] = '{OP_DIV,           8'd200, 8'd7,   OP_DIV,  9'd28,   1'b0, 1'b1};
    tbl[4] = '{OP_DIV,           8'd9,   8'd0,   5'd0,    9'h1FF,  1'b1, 1'b1};
    tbl[5] = '{OP_MULT,          8'd255, 8'd255, OP_MULT, 9'd1,    1'b1, 1'b1};
    tbl[6] = '{OP_CLR,           8'd0,   8'd0,   OP_CLR,  9'd0,    1'b0, 1'b0};
    tbl[7] = '{5'b01111,         8'd1,   8'd1,   OP_ADD,  9'd2,    1'b0, 1'b1};
    tbl[8] = '{OP_CLR | OP_SUB,  8'd3,   8'd4,   OP_CLR,  9'd0,    1'b0, 1'b0};

    // Reset state of both controllers.
    #1;
    rst_n0 = 1'b0;
    rst_n1 = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_state_dut0", o0, '0);
    chk("reset_state_dut1", o1, '0);
    rst_n0 = 1'b1;
    rst_n1 = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_after_reset_dut0", o0, '0);
    chk("idle_after_reset_dut1", o1, '0);

    // Directed vectors: each button held 10 cycles.
    for (int i = 0; i < 9; i++) begin
      run_window(0, tbl[i].a, tbl[i].b, tbl[i].mask, 0, 10, 5'd0, 0, 0, -1, 30);
      check_window(0, tbl[i].exp_op, tbl[i].exp_res, tbl[i].exp_div0, tbl[i].exp_multi,
                   tbl[i].a, tbl[i].b, $sformatf("row%0d", i));
    end
    m_res   = tbl[8].exp_res;
    m_div0  = tbl[8].exp_div0;
    m_multi = tbl[8].exp_multi;

    // Glitch shorter than the debounce window is never accepted.
    run_window(0, 8'd1, 8'd2, OP_SUB, 0, Dbnc0 - 1, 5'd0, 0, 0, -1, 20);
    chk("glitch_op_cycles", w_nop, 0);
    chk("glitch_ndone", w_ndone, 0);
    chk("glitch_busy", w_busy, 0);
    chk("glitch_result", w_end.res, m_res);

    // Randomized presses against the reference model.
    for (int it = 0; it < 24; it++) begin
      logic [4:0] mask, eop;
      logic [7:0] a, b;
      int         w;
      mask = 5'($urandom_range(1, 31));
      a    = 8'($urandom_range(0, 255));
      b    = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      if (mask[4]) begin
        eop     = OP_CLR;
        m_res   = 9'd0;
        m_div0  = 1'b0;
        m_multi = 1'b0;
      end else begin
        w = -1;
        for (int i = 3; i >= 0; i--) begin
          if (mask[i] && w < 0) w = i;
        end
        if ($countones(mask) > 1) m_multi = 1'b1;
        if (w == 0 && b == 8'd0) begin
          eop    = 5'd0;
          m_div0 = 1'b1;
          m_res  = 9'h1FF;
        end else begin
          eop   = 5'(1 << w);
          m_res = ref_calc(w, a, b);
        end
      end
      run_window(0, a, b, mask, 0, 10, 5'd0, 0, 0, -1, 30);
      check_window(0, eop, m_res, m_div0, m_multi, a, b, $sformatf("rnd%0d", it));
    end

    // Long latency: a second ADD press lands during WAIT and is dropped.
    run_window(1, 8'd50, 8'd25, OP_ADD, 0, 2, OP_ADD, 4, 6, -1, 20);
    check_window(1, OP_ADD, 9'd75, 1'b0, 1'b0, 8'd50, 8'd25, "lat4_drop");

    // Reset during WAIT: everything clears at once and done never pulses.
    run_window(1, 8'd7, 8'd8, OP_ADD, 0, 2, 5'd0, 0, 0, 6, 20);
    chk("rst_mid_op_cycles", w_nop, 1);
    chk("rst_mid_ndone", w_ndone, 0);
    chk("rst_mid_busy_cycles", w_busy, 3);
    chk("rst_mid_end_state", w_end, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

endmodule
